// File: rtl/cvxif_acc_dispatcher_if.sv
// Bundle of every handshake and data signal between the core, the
// dispatcher and the attached coprocessors. The dispatcher uses the slave
// view; the core/accelerator side (or a bench) uses the master view.
interface cvxif_acc_dispatcher_if #(
  parameter int NUM_ACC    = 2,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
);
  logic                          core_issue_valid;
  logic                          core_issue_ready;
  logic [31:0]                   core_issue_instr;
  logic [ID_WIDTH-1:0]           core_issue_id;
  logic                          core_issue_accept;
  logic                          core_issue_writeback;

  logic [NUM_ACC-1:0]            acc_issue_valid;
  logic [NUM_ACC-1:0]            acc_issue_ready;
  logic [NUM_ACC-1:0]            acc_issue_accept;
  logic [NUM_ACC-1:0]            acc_issue_writeback;
  logic [31:0]                   acc_issue_instr;
  logic [ID_WIDTH-1:0]           acc_issue_id;

  logic                          core_commit_valid;
  logic [ID_WIDTH-1:0]           core_commit_id;
  logic                          core_commit_kill;
  logic [NUM_ACC-1:0]            acc_commit_valid;
  logic [ID_WIDTH-1:0]           acc_commit_id;
  logic                          acc_commit_kill;

  logic [NUM_ACC-1:0]            acc_result_valid;
  logic [NUM_ACC-1:0]            acc_result_ready;
  logic [NUM_ACC-1:0]            acc_result_we;
  logic [NUM_ACC*ID_WIDTH-1:0]   acc_result_id;
  logic [NUM_ACC*5-1:0]          acc_result_rd;
  logic [NUM_ACC*DATA_WIDTH-1:0] acc_result_data;

  logic                          core_result_valid;
  logic                          core_result_ready;
  logic [ID_WIDTH-1:0]           core_result_id;
  logic [4:0]                    core_result_rd;
  logic [DATA_WIDTH-1:0]         core_result_data;
  logic                          core_result_we;

  logic                          busy;

  modport slave (
    input  core_issue_valid, core_issue_instr, core_issue_id,
    input  acc_issue_ready, acc_issue_accept, acc_issue_writeback,
    input  core_commit_valid, core_commit_id, core_commit_kill,
    input  acc_result_valid, acc_result_we, acc_result_id, acc_result_rd, acc_result_data,
    input  core_result_ready,
    output core_issue_ready, core_issue_accept, core_issue_writeback,
    output acc_issue_valid, acc_issue_instr, acc_issue_id,
    output acc_commit_valid, acc_commit_id, acc_commit_kill,
    output acc_result_ready,
    output core_result_valid, core_result_id, core_result_rd, core_result_data, core_result_we,
    output busy
  );

  modport master (
    output core_issue_valid, core_issue_instr, core_issue_id,
    output acc_issue_ready, acc_issue_accept, acc_issue_writeback,
    output core_commit_valid, core_commit_id, core_commit_kill,
    output acc_result_valid, acc_result_we, acc_result_id, acc_result_rd, acc_result_data,
    output core_result_ready,
    input  core_issue_ready, core_issue_accept, core_issue_writeback,
    input  acc_issue_valid, acc_issue_instr, acc_issue_id,
    input  acc_commit_valid, acc_commit_id, acc_commit_kill,
    input  acc_result_ready,
    input  core_result_valid, core_result_id, core_result_rd, core_result_data, core_result_we,
    input  busy
  );
endinterface

// File: rtl/cvxif_acc_dispatcher.sv
// CV-X-IF dispatcher: routes core issue requests to one of NUM_ACC
// coprocessors by major opcode, tracks which accelerator owns each
// in-flight instruction ID so commits reach the right unit, and merges the
// accelerators' result streams back to the core with a round-robin arbiter.
module cvxif_acc_dispatcher #(
  parameter int                   NUM_ACC         = 2,
  parameter int                   ID_WIDTH        = 4,
  parameter int                   DATA_WIDTH      = 32,
  parameter int                   MAX_OUTSTANDING = 4,
  // Entry k lives at bits [7k+6:7k] and selects accelerator k.
  parameter logic [NUM_ACC*7-1:0] OPCODES         = {7'h2B, 7'h0B}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cvxif_acc_dispatcher_if.slave  bus
);

  localparam int OW    = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int DEPTH = 2 ** ID_WIDTH;

  typedef enum logic {S_IDLE, S_HOLD} res_state_e;

  // Ownership table: one slot per instruction ID.
  logic                  tbl_vld_q [DEPTH];
  logic [OW-1:0]         tbl_own_q [DEPTH];
  logic                  tbl_wb_q  [DEPTH];
  logic [CW-1:0]         count_q, count_d;

  res_state_e            state_q, state_d;
  logic [OW-1:0]         ptr_q;
  logic [ID_WIDTH-1:0]   res_id_q;
  logic [4:0]            res_rd_q;
  logic [DATA_WIDTH-1:0] res_data_q;
  logic                  res_we_q;

  logic                  match;
  logic [OW-1:0]         match_idx;
  logic                  full;
  logic [NUM_ACC-1:0]    iss_valid;
  logic                  iss_ready, iss_accept, iss_wb;
  logic                  alloc;
  logic                  cm_hit, free_c, free_r;
  logic [1:0]            nfree;
  logic [NUM_ACC-1:0]    cm_valid;
  logic                  grant_vld;
  logic [OW-1:0]         grant_idx, cand;
  logic [NUM_ACC-1:0]    res_ready;
  logic                  res_valid, res_hs;
  logic [CW:0]           count_sum;

  // Opcode decode: loop runs high to low so the lowest matching entry wins.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int k = NUM_ACC - 1; k >= 0; k--) begin
      if (bus.core_issue_instr[6:0] == OPCODES[k*7 +: 7]) begin
        match     = 1'b1;
        match_idx = OW'(k);
      end
    end
  end

  assign full = (count_q == CW'(MAX_OUTSTANDING));

  // Issue routing: unknown opcodes are waved through (ready, not accepted);
  // matching ones stall while the outstanding table is full.
  always_comb begin
    iss_valid  = '0;
    iss_ready  = 1'b1;
    iss_accept = 1'b0;
    iss_wb     = 1'b0;
    if (match) begin
      if (full) begin
        iss_ready = 1'b0;
      end else begin
        iss_valid[match_idx] = bus.core_issue_valid;
        iss_ready            = bus.acc_issue_ready[match_idx];
        iss_accept           = bus.acc_issue_accept[match_idx];
        iss_wb               = bus.acc_issue_writeback[match_idx];
      end
    end
  end

  assign alloc = bus.core_issue_valid & iss_ready & iss_accept & match & ~full;

  // Commit routing to the owning accelerator, plus the two free conditions.
  always_comb begin
    cm_hit   = tbl_vld_q[bus.core_commit_id];
    cm_valid = '0;
    for (int k = 0; k < NUM_ACC; k++) begin
      cm_valid[k] = cm_hit & bus.core_commit_valid &
                    (tbl_own_q[bus.core_commit_id] == OW'(k));
    end
    free_c = bus.core_commit_valid & cm_hit &
             (bus.core_commit_kill | ~tbl_wb_q[bus.core_commit_id]);
    free_r = res_hs & tbl_vld_q[res_id_q];
    // A commit and a result retiring the same ID only release one slot.
    if (free_c && free_r && (bus.core_commit_id == res_id_q)) nfree = 2'd1;
    else                                                      nfree = {1'b0, free_c} + {1'b0, free_r};
    count_sum = {1'b0, count_q} + (CW+1)'(alloc) - (CW+1)'(nfree);
    count_d   = count_sum[CW-1:0];
  end

  // Table valid bits and outstanding count; frees first, then allocation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl_vld_q[i] <= 1'b0;
      count_q <= '0;
    end else begin
      if (free_c) tbl_vld_q[bus.core_commit_id] <= 1'b0;
      if (free_r) tbl_vld_q[res_id_q]           <= 1'b0;
      if (alloc)  tbl_vld_q[bus.core_issue_id]  <= 1'b1;
      count_q <= count_d;
    end
  end

  // Owner/writeback payload is only meaningful while the valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tbl_own_q[bus.core_issue_id] <= match_idx;
      tbl_wb_q[bus.core_issue_id]  <= iss_wb;
    end
  end

  // Result FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Result FSM next state and outputs: round-robin grant in IDLE, hold in HOLD.
  always_comb begin
    state_d   = state_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    res_ready = '0;
    res_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        for (int i = NUM_ACC - 1; i >= 0; i--) begin
          cand = OW'((int'(ptr_q) + i) % NUM_ACC);
          if (bus.acc_result_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
          end
        end
        if (grant_vld) begin
          res_ready[grant_idx] = 1'b1;
          state_d              = S_HOLD;
        end
      end
      S_HOLD: begin
        res_valid = 1'b1;
        if (bus.core_result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign res_hs = res_valid & bus.core_result_ready;

  // Capture the granted result and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      res_id_q   <= '0;
      res_rd_q   <= '0;
      res_data_q <= '0;
      res_we_q   <= 1'b0;
    end else if (grant_vld) begin
      ptr_q      <= OW'((int'(grant_idx) + 1) % NUM_ACC);
      res_id_q   <= bus.acc_result_id[grant_idx*ID_WIDTH +: ID_WIDTH];
      res_rd_q   <= bus.acc_result_rd[grant_idx*5 +: 5];
      res_data_q <= bus.acc_result_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      res_we_q   <= bus.acc_result_we[grant_idx];
    end
  end

  assign bus.core_issue_ready     = iss_ready;
  assign bus.core_issue_accept    = iss_accept;
  assign bus.core_issue_writeback = iss_wb;
  assign bus.acc_issue_valid      = iss_valid;
  assign bus.acc_issue_instr      = bus.core_issue_instr;
  assign bus.acc_issue_id         = bus.core_issue_id;
  assign bus.acc_commit_valid     = cm_valid;
  assign bus.acc_commit_id        = bus.core_commit_id;
  assign bus.acc_commit_kill      = bus.core_commit_kill;
  assign bus.acc_result_ready     = res_ready;
  assign bus.core_result_valid    = res_valid;
  assign bus.core_result_id       = res_id_q;
  assign bus.core_result_rd       = res_rd_q;
  assign bus.core_result_data     = res_data_q;
  assign bus.core_result_we       = res_we_q;
  assign bus.busy                 = (count_q != '0);

endmodule

// File: tb/tb_cvxif_acc_dispatcher.sv
// Bench for cvxif_acc_dispatcher: directed scenarios followed by random
// traffic, every output compared each cycle against a behavioural model
// built from an outstanding-ID set and a single held-result slot.
module tb_cvxif_acc_dispatcher;
  localparam int NA = 2;
  localparam int IW = 4;
  localparam int DW = 32;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cvxif_acc_dispatcher_if #(.NUM_ACC(NA), .ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  cvxif_acc_dispatcher #(
    .NUM_ACC(NA), .ID_WIDTH(IW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO),
    .OPCODES({7'h2B, 7'h0B})
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  int total = 0;
  int bad = 0;

  // Reference model state.
  bit            mv  [16];
  int            mown[16];
  bit            mwb [16];
  bit            held;
  logic [IW-1:0] hid;
  logic [4:0]    hrd;
  logic [DW-1:0] hdata;
  logic          hwe;
  int            mptr;
  logic [6:0]    opc [NA] = '{7'h0B, 7'h2B};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 16; i++) if (mv[i]) c++;
    return c;
  endfunction

  function automatic int m_match(input logic [31:0] instr);
    for (int k = 0; k < NA; k++) if (instr[6:0] == opc[k]) return k;
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    held = 1'b0; hid = '0; hrd = '0; hdata = '0; hwe = 1'b0; mptr = 0;
  endtask

  task automatic set_idle();
    bus.core_issue_valid = 1'b0; bus.core_issue_instr = '0; bus.core_issue_id = '0;
    bus.acc_issue_ready = '0; bus.acc_issue_accept = '0; bus.acc_issue_writeback = '0;
    bus.core_commit_valid = 1'b0; bus.core_commit_id = '0; bus.core_commit_kill = 1'b0;
    bus.acc_result_valid = '0; bus.acc_result_we = '0; bus.acc_result_id = '0;
    bus.acc_result_rd = '0; bus.acc_result_data = '0; bus.core_result_ready = 1'b0;
  endtask

  // Check every output against the model, advance the model, move one cycle.
  task automatic step();
    int k, g, cid;
    bit full, alloc, fc, fr;
    logic e_rdy, e_acc, e_wb;
    logic [NA-1:0] e_av, e_cv, e_rr;
    #1;
    k = m_match(bus.core_issue_instr);
    full = (m_count() == MO);
    e_av = '0; e_rdy = 1'b1; e_acc = 1'b0; e_wb = 1'b0;
    if (k >= 0) begin
      if (full) e_rdy = 1'b0;
      else begin
        e_av[k] = bus.core_issue_valid;
        e_rdy   = bus.acc_issue_ready[k];
        e_acc   = bus.acc_issue_accept[k];
        e_wb    = bus.acc_issue_writeback[k];
      end
    end
    cid = int'(bus.core_commit_id);
    e_cv = '0;
    if (mv[cid]) e_cv[mown[cid]] = bus.core_commit_valid;
    e_rr = '0; g = -1;
    if (!held) begin
      for (int i = 0; i < NA; i++) begin
        if (g < 0 && bus.acc_result_valid[(mptr + i) % NA]) g = (mptr + i) % NA;
      end
      if (g >= 0) e_rr[g] = 1'b1;
    end
    chk("issue_ready", bus.core_issue_ready, e_rdy);
    chk("issue_accept", bus.core_issue_accept, e_acc);
    chk("issue_wb", bus.core_issue_writeback, e_wb);
    chk("acc_issue_valid", bus.acc_issue_valid, e_av);
    chk("acc_issue_instr", bus.acc_issue_instr, bus.core_issue_instr);
    chk("acc_issue_id", bus.acc_issue_id, bus.core_issue_id);
    chk("acc_commit_valid", bus.acc_commit_valid, e_cv);
    chk("acc_commit_kill", bus.acc_commit_kill, bus.core_commit_kill);
    chk("acc_commit_id", bus.acc_commit_id, bus.core_commit_id);
    chk("acc_result_ready", bus.acc_result_ready, e_rr);
    chk("core_result_valid", bus.core_result_valid, held);
    if (held) begin
      chk("core_result_id", bus.core_result_id, hid);
      chk("core_result_rd", bus.core_result_rd, hrd);
      chk("core_result_data", bus.core_result_data, hdata);
      chk("core_result_we", bus.core_result_we, hwe);
    end
    chk("busy", bus.busy, m_count() != 0);
    // model update for the coming edge
    alloc = (k >= 0) && !full && bus.core_issue_valid && bus.acc_issue_ready[k] && bus.acc_issue_accept[k];
    fc = bus.core_commit_valid && mv[cid] && (bus.core_commit_kill || !mwb[cid]);
    fr = held && bus.core_result_ready && mv[hid];
    if (fc) mv[cid] = 1'b0;
    if (fr) mv[hid] = 1'b0;
    if (alloc) begin
      mv[bus.core_issue_id]   = 1'b1;
      mown[bus.core_issue_id] = k;
      mwb[bus.core_issue_id]  = bus.acc_issue_writeback[k];
    end
    if (held) begin
      if (bus.core_result_ready) held = 1'b0;
    end else if (g >= 0) begin
      held  = 1'b1;
      hid   = bus.acc_result_id[g*IW +: IW];
      hrd   = bus.acc_result_rd[g*5 +: 5];
      hdata = bus.acc_result_data[g*DW +: DW];
      hwe   = bus.acc_result_we[g];
      mptr  = (g + 1) % NA;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [6:0] op, input int id, input logic [NA-1:0] wb);
    bus.core_issue_valid = 1'b1;
    bus.core_issue_instr = {25'h0ABCDE, op};
    bus.core_issue_id = IW'(id);
    bus.acc_issue_ready = '1; bus.acc_issue_accept = '1; bus.acc_issue_writeback = wb;
  endtask

  task automatic commit(input int id, input logic kill);
    bus.core_commit_valid = 1'b1; bus.core_commit_id = IW'(id); bus.core_commit_kill = kill;
  endtask

  task automatic reset_checks();
    chk("rst_result_valid", bus.core_result_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_result_id", bus.core_result_id, '0);
    chk("rst_result_data", bus.core_result_data, '0);
    chk("rst_result_we", bus.core_result_we, 1'b0);
  endtask

  initial begin
    int id;
    set_idle();
    m_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    // Unknown opcode passes straight through.
    issue(7'h33, 2, 2'b11); step();
    set_idle(); step();

    // Opcode 2B to acc1 with writeback, then kill-commit and a dropped commit.
    issue(7'h2B, 3, 2'b11); step();
    set_idle(); step();
    commit(3, 1'b1); step();
    commit(5, 1'b0); step();
    set_idle(); step();

    // Fill the table, stall a fifth, release one slot with a kill.
    for (int i = 0; i < 4; i++) begin issue(7'h0B, i, 2'b11); step(); end
    issue(7'h0B, 4, 2'b11); step(); step();
    commit(0, 1'b1); step();
    bus.core_commit_valid = 1'b0; step();
    set_idle(); commit(1, 1'b1); step();
    // Allocate and free in the same cycle; id 5 has no writeback.
    issue(7'h0B, 5, 2'b00); commit(2, 1'b1); step();
    set_idle(); commit(5, 1'b0); step();
    commit(3, 1'b0); step();
    commit(4, 1'b1); step();
    set_idle(); step();

    // Simultaneous results: acc0 first, acc1 two cycles later.
    bus.core_result_ready = 1'b1;
    bus.acc_result_valid = 2'b11; bus.acc_result_we = 2'b01;
    bus.acc_result_id = {4'd9, 4'd3}; bus.acc_result_rd = {5'd2, 5'd1};
    bus.acc_result_data = {32'h5555_5555, 32'hAAAA_AAAA};
    step();
    bus.acc_result_valid = 2'b10; step();
    step();
    bus.acc_result_valid = 2'b00; step();
    step();

    // Reset while a result is held and the core is stalling.
    set_idle();
    issue(7'h2B, 7, 2'b10); step();
    set_idle();
    bus.acc_result_valid = 2'b01; bus.acc_result_id = {4'd0, 4'd7};
    bus.acc_result_data = {32'h0, 32'h1234_5678}; bus.acc_result_we = 2'b01;
    step();
    bus.acc_result_valid = 2'b00; step(); step();
    #2 rst_n = 1'b0;
    #1 reset_checks();
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      logic [6:0] op;
      case ($urandom_range(0, 3))
        0: op = 7'h0B;
        1: op = 7'h2B;
        2: op = 7'h33;
        default: op = 7'($urandom());
      endcase
      id = int'($urandom_range(0, 15));
      for (int t = 0; t < 16 && mv[id]; t++) id = (id + 1) % 16;
      bus.core_issue_valid = ($urandom_range(0, 9) < 7);
      bus.core_issue_instr = {25'($urandom()), op};
      bus.core_issue_id = IW'(id);
      bus.acc_issue_ready = NA'($urandom()); bus.acc_issue_accept = NA'($urandom());
      bus.acc_issue_writeback = NA'($urandom());
      bus.core_commit_valid = ($urandom_range(0, 9) < 3);
      id = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        for (int t = 0; t < 16 && !mv[id]; t++) id = (id + 1) % 16;
      bus.core_commit_id = IW'(id);
      bus.core_commit_kill = 1'($urandom());
      bus.acc_result_valid = NA'($urandom()); bus.acc_result_we = NA'($urandom());
      bus.acc_result_id = (NA*IW)'($urandom()); bus.acc_result_rd = (NA*5)'($urandom());
      bus.acc_result_data = {$urandom(), $urandom()};
      bus.core_result_ready = ($urandom_range(0, 9) < 7);
      step();
      if (c == 700) begin
        #2 rst_n = 1'b0;
        #1 reset_checks();
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
